cart_bus_initiator: RTL and testbench

- Host-side master for the WonderSwan cartridge bus. Converts a single-command request/response interface into correctly sequenced nSel/nIO/nOE/nWE cycles, with address and data driven onto the cartridge pins.
- Used in the bring-up/validation harness to drive the cartridge FPGA as the console does: bank register writes, memory reads, SPI register access.
- Tristate resolution is done at the harness top level via DataOE.

---
 rtl/cart_bus_initiator.sv | 183 ++++++++++++++++++
 tb/tb_cart_bus_initiator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_initiator.sv
// Host-side initiator for the WonderSwan cartridge bus: turns one accepted
// command into a SETUP/STROBE/HOLD/RECOVER cycle on nSel/nIO/nOE/nWE.
module cart_bus_initiator #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic        FastClk,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic        CmdWrite,
  input  logic        CmdIO,
  input  logic [19:0] CmdAddr,
  input  logic [15:0] CmdWData,
  output logic        RspValid,
  output logic [15:0] RspData,
  output logic        nSel,
  output logic        nIO,
  output logic        nOE,
  output logic        nWE,
  output logic [8:0]  AddrLo,
  output logic [3:0]  AddrHi,
  output logic [15:0] DataOut,
  output logic        DataOE,
  input  logic [15:0] DataIn
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || RECOVER_CYC < 1 || RECOVER_CYC > 15) begin : g_bad_param
    $error("cart_bus_initiator: every cycle parameter must be in 1..15");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        cmd_write, cmd_io;
  logic [15:0] capture;
  logic        eff_write, eff_io;
  logic [15:0] read_word;

  logic        nxt_n_sel, nxt_n_io, nxt_n_oe, nxt_n_we, nxt_data_oe, nxt_rsp_valid;
  logic [8:0]  nxt_addr_lo;
  logic [3:0]  nxt_addr_hi;
  logic [15:0] nxt_data_out, nxt_rsp_data;

  // Address bits [15:9] have no pin on this bus.
  logic unused_addr;
  assign unused_addr = ^CmdAddr[15:9];

  function automatic logic [3:0] load_count(input state_t s);
    case (s)
      SETUP:   return 4'(SETUP_CYC - 1);
      STROBE:  return 4'(STROBE_CYC - 1);
      HOLD:    return 4'(HOLD_CYC - 1);
      RECOVER: return 4'(RECOVER_CYC - 1);
      default: return 4'd0;
    endcase
  endfunction

  assign CmdReady  = (state == IDLE) & ~Reset;
  // In IDLE the command is being accepted this edge, so use the live inputs.
  assign eff_write = (state == IDLE) ? CmdWrite : cmd_write;
  assign eff_io    = (state == IDLE) ? CmdIO    : cmd_io;
  assign read_word = cmd_io ? {8'h00, DataIn[7:0]} : DataIn;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge FastClk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE:    if (CmdValid)    next_state = SETUP;
      SETUP:   if (cnt == 4'd0) next_state = STROBE;
      STROBE:  if (cnt == 4'd0) next_state = HOLD;
      HOLD:    if (cnt == 4'd0) next_state = RECOVER;
      RECOVER: if (cnt == 4'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (next_state != state) next_cnt = load_count(next_state);
    else if (cnt != 4'd0)    next_cnt = cnt - 4'd1;
  end

  // Next values of the registered pins, decoded from the state being entered.
  always_comb begin
    nxt_n_sel     = 1'b1;
    nxt_n_io      = 1'b1;
    nxt_n_oe      = 1'b1;
    nxt_n_we      = 1'b1;
    nxt_data_oe   = 1'b0;
    nxt_rsp_valid = 1'b0;
    nxt_addr_lo   = AddrLo;
    nxt_addr_hi   = AddrHi;
    nxt_data_out  = DataOut;
    nxt_rsp_data  = RspData;
    case (next_state)
      SETUP: begin
        nxt_n_sel   = 1'b0;
        nxt_n_io    = ~eff_io;
        nxt_data_oe = eff_write;
        if (state == IDLE) begin
          if (CmdIO) begin
            nxt_addr_hi = CmdAddr[7:4];
            nxt_addr_lo = {5'h00, CmdAddr[3:0]};
          end else begin
            nxt_addr_hi = CmdAddr[19:16];
            nxt_addr_lo = CmdAddr[8:0];
          end
          if (!CmdWrite)  nxt_data_out = 16'h0000;
          else if (CmdIO) nxt_data_out = {8'h00, CmdWData[7:0]};
          else            nxt_data_out = CmdWData;
        end
      end
      STROBE: begin
        nxt_n_sel   = 1'b0;
        nxt_n_io    = ~cmd_io;
        nxt_data_oe = cmd_write;
        nxt_n_oe    = cmd_write;
        nxt_n_we    = ~cmd_write;
      end
      HOLD: begin
        nxt_n_sel   = 1'b0;
        nxt_n_io    = ~cmd_io;
        nxt_data_oe = cmd_write;
        if (next_cnt == 4'd0) begin
          nxt_rsp_valid = 1'b1;
          if (!cmd_write) nxt_rsp_data = (state == STROBE) ? read_word : capture;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      cmd_write <= 1'b0;
      cmd_io    <= 1'b0;
      capture   <= 16'h0000;
      nSel      <= 1'b1;
      nIO       <= 1'b1;
      nOE       <= 1'b1;
      nWE       <= 1'b1;
      AddrLo    <= 9'h000;
      AddrHi    <= 4'h0;
      DataOut   <= 16'h0000;
      DataOE    <= 1'b0;
      RspValid  <= 1'b0;
      RspData   <= 16'h0000;
    end else begin
      if (state == IDLE && CmdValid) begin
        cmd_write <= CmdWrite;
        cmd_io    <= CmdIO;
      end
      // Bus data is taken on the edge that ends the last strobe cycle.
      if (state == STROBE && next_state == HOLD) capture <= read_word;
      nSel     <= nxt_n_sel;
      nIO      <= nxt_n_io;
      nOE      <= nxt_n_oe;
      nWE      <= nxt_n_we;
      AddrLo   <= nxt_addr_lo;
      AddrHi   <= nxt_addr_hi;
      DataOut  <= nxt_data_out;
      DataOE   <= nxt_data_oe;
      RspValid <= nxt_rsp_valid;
      RspData  <= nxt_rsp_data;
    end
  end

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Directed bench for cart_bus_initiator: reset, IO/memory reads and writes,
// back-to-back commands and reset in the middle of a strobe.
module tb_cart_bus_initiator;

  logic        FastClk, Reset, CmdValid, CmdReady, CmdWrite, CmdIO;
  logic [19:0] CmdAddr;
  logic [15:0] CmdWData, RspData, DataOut, DataIn;
  logic        RspValid, nSel, nIO, nOE, nWE, DataOE;
  logic [8:0]  AddrLo;
  logic [3:0]  AddrHi;
  logic [15:0] model_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    int          lat;       // ticks after the accept edge until CmdReady returns
    int          nsel_low;
    int          nio_low;
    int          noe_low;
    int          nwe_low;
    int          oe_cycles;
    int          rsp_count;
    int          rsp_idx;   // 1-based cycle after accept carrying RspValid
    int          recov;     // nSel-high cycles just before CmdReady returns
    int          viol;      // strobe with nSel high, or both strobes low
    logic [15:0] rsp_data;
    logic [3:0]  addr_hi;
    logic [8:0]  addr_lo;
    logic [15:0] data_out;
  } op_stats_t;

  op_stats_t s;

  cart_bus_initiator dut (
    .FastClk(FastClk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdWrite(CmdWrite), .CmdIO(CmdIO), .CmdAddr(CmdAddr), .CmdWData(CmdWData),
    .RspValid(RspValid), .RspData(RspData), .nSel(nSel), .nIO(nIO), .nOE(nOE),
    .nWE(nWE), .AddrLo(AddrLo), .AddrHi(AddrHi), .DataOut(DataOut),
    .DataOE(DataOE), .DataIn(DataIn)
  );

  // Cartridge model drives the bus only while the read strobe is low.
  assign DataIn = nOE ? 16'h0000 : model_data;

  initial FastClk = 1'b0;
  always #5 FastClk = ~FastClk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge FastClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; walks the bus cycle until CmdReady.
  task automatic run_op(output op_stats_t st);
    st = '0;
    st.lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (CmdReady) begin
        st.lat = i;
        break;
      end
      if (i == 0) begin
        st.addr_hi  = AddrHi;
        st.addr_lo  = AddrLo;
        st.data_out = DataOut;
      end
      if (!nSel) st.nsel_low++;
      if (!nIO)  st.nio_low++;
      if (!nOE)  st.noe_low++;
      if (!nWE)  st.nwe_low++;
      if (DataOE) st.oe_cycles++;
      if (nSel) st.recov++; else st.recov = 0;
      if ((!nOE || !nWE) && nSel) st.viol++;
      if (!nOE && !nWE) st.viol++;
      if (RspValid) begin
        st.rsp_count++;
        st.rsp_idx  = i + 1;
        st.rsp_data = RspData;
      end
      tick();
    end
  endtask

  task automatic issue(input logic wr, input logic io, input logic [19:0] addr,
                       input logic [15:0] wdata);
    CmdValid = 1'b1;
    CmdWrite = wr;
    CmdIO    = io;
    CmdAddr  = addr;
    CmdWData = wdata;
  endtask

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b0; CmdIO = 1'b0;
    CmdAddr = '0; CmdWData = '0; model_data = 16'h0000;
    repeat (3) tick();

    // Reset state
    check("rst_ready", CmdReady, 1'b0);
    check("rst_nsel", nSel, 1'b1);
    check("rst_strobes", {nOE, nWE, nIO}, 3'b111);
    check("rst_addr", {AddrHi, AddrLo}, 13'h0);
    check("rst_dataout", DataOut, 16'h0000);
    check("rst_oe_rsp", {DataOE, RspValid}, 2'b00);
    check("rst_rspdata", RspData, 16'h0000);
    Reset = 1'b0;
    #1;
    check("rel_ready", CmdReady, 1'b1);
    repeat (4) tick();
    check("idle_ready", CmdReady, 1'b1);
    check("idle_pins", {nSel, nOE, nWE, nIO, DataOE}, 5'b11110);

    // IO write, port 0xC2, data 0x05; inputs scrambled after acceptance
    issue(1'b1, 1'b1, 20'h000C2, 16'h1205);
    tick();
    CmdValid = 1'b0; CmdAddr = 20'hFFFFF; CmdWData = 16'hFFFF;
    run_op(s);
    check("iow_addrhi", s.addr_hi, 4'hC);
    check("iow_addrlo", s.addr_lo, 9'h002);
    check("iow_dataout", s.data_out, 16'h0005);
    check("iow_nsel_low", s.nsel_low, 7);
    check("iow_nio_low", s.nio_low, 7);
    check("iow_nwe_low", s.nwe_low, 4);
    check("iow_noe_low", s.noe_low, 0);
    check("iow_oe_cycles", s.oe_cycles, 7);
    check("iow_rsp_count", s.rsp_count, 1);
    check("iow_rsp_cycle", s.rsp_idx, 7);
    check("iow_latency", s.lat, 8);
    check("iow_viol", s.viol, 0);
    check("iow_rspdata_held", RspData, 16'h0000);

    // Memory read at 0x2_0123
    model_data = 16'hBEEF;
    issue(1'b0, 1'b0, 20'h20123, 16'h7777);
    tick();
    CmdValid = 1'b0;
    run_op(s);
    check("mrd_addrhi", s.addr_hi, 4'h2);
    check("mrd_addrlo", s.addr_lo, 9'h123);
    check("mrd_nio_low", s.nio_low, 0);
    check("mrd_noe_low", s.noe_low, 4);
    check("mrd_oe_cycles", s.oe_cycles, 0);
    check("mrd_rspdata", s.rsp_data, 16'hBEEF);
    check("mrd_rsp_cycle", s.rsp_idx, 7);
    check("mrd_rspdata_held", RspData, 16'hBEEF);

    // IO read, port 0xE2
    model_data = 16'hA581;
    issue(1'b0, 1'b1, 20'h000E2, 16'h0000);
    tick();
    CmdValid = 1'b0;
    run_op(s);
    check("ior_addr", {s.addr_hi, s.addr_lo}, {4'hE, 9'h002});
    check("ior_nio_low", s.nio_low, 7);
    check("ior_rspdata", s.rsp_data, 16'h0081);

    // Back-to-back: CmdValid stays high, second command waits on the bus
    issue(1'b1, 1'b0, 20'h12345, 16'h1234);
    tick();
    issue(1'b0, 1'b0, 20'h0ABCD, 16'h0000);
    model_data = 16'h5A5A;
    run_op(s);
    check("b2b1_addr", {s.addr_hi, s.addr_lo}, {4'h1, 9'h145});
    check("b2b1_dataout", s.data_out, 16'h1234);
    check("b2b1_ready_after", s.lat, 8);
    check("b2b1_recover_gap", s.recov, 1);
    check("b2b1_rspdata_held", s.rsp_data, 16'h0081);
    check("b2b_handshake", CmdValid & CmdReady, 1'b1);
    tick();
    CmdValid = 1'b0;
    run_op(s);
    check("b2b2_addr", {s.addr_hi, s.addr_lo}, {4'h0, 9'h1CD});
    check("b2b2_rspdata", s.rsp_data, 16'h5A5A);
    check("b2b2_rsp_count", s.rsp_count, 1);

    // Reset on the second STROBE cycle of a write
    issue(1'b1, 1'b0, 20'h30055, 16'hCAFE);
    tick();
    CmdValid = 1'b0;
    repeat (3) tick();
    check("abort_pre_strobe", {nSel, nWE, DataOE}, 3'b001);
    Reset = 1'b1;
    tick();
    check("abort_pins", {nSel, nWE, nOE, nIO, DataOE}, 5'b11110);
    check("abort_addr_data", {AddrHi, AddrLo, DataOut}, 29'h0);
    check("abort_ready_in_reset", CmdReady, 1'b0);
    check("abort_rspdata", RspData, 16'h0000);
    Reset = 1'b0;
    #1;
    check("abort_ready_after", CmdReady, 1'b1);
    s = '0;
    for (int i = 0; i < 12; i++) begin
      if (RspValid) s.rsp_count++;
      if (!nSel) s.nsel_low++;
      tick();
    end
    check("abort_no_rsp", s.rsp_count, 0);
    check("abort_no_retry", s.nsel_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
